// File: rtl/cpu_pkg.sv
// Shared constants and types for the mini CPU front end.
package cpu_pkg;
  localparam int unsigned PC_WIDTH = 64;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, DRAIN, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory request/response, redirect input and decode output.
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH = cpu_pkg::PC_WIDTH
) ();
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_rsp_valid;
  logic [31:0]         imem_rsp_data;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                instr_valid;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                instr_ready;
  logic                fetch_fault;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO with a registered head; flush overrides push and pop.
module fetch_buffer #(
  parameter int unsigned PC_WIDTH = cpu_pkg::PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic                flush_i,
  input  logic [31:0]         instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic [1:0]          count_o,
  output logic                valid_o,
  output logic [31:0]         head_instr_o,
  output logic [PC_WIDTH-1:0] head_pc_o
);
  import cpu_pkg::*;

  logic [1:0]          count_q, count_d;
  logic [31:0]         head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
  logic [PC_WIDTH-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic                pop_en;

  always_comb begin
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    pop_en       = pop_i && (count_q != 2'd0);
    if (flush_i) begin
      count_d = 2'd0;
    end else if (push_i && pop_en) begin
      if (count_q == 2'd1) begin
        head_instr_d = instr_i;
        head_pc_d    = pc_i;
      end else begin
        head_instr_d = tail_instr_q;
        head_pc_d    = tail_pc_q;
        tail_instr_d = instr_i;
        tail_pc_d    = pc_i;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) begin
        head_instr_d = instr_i;
        head_pc_d    = pc_i;
      end else begin
        tail_instr_d = instr_i;
        tail_pc_d    = pc_i;
      end
      count_d = count_q + 2'd1;
    end else if (pop_en) begin
      // Only shift when the tail holds a live word, so instr never shows a stale slot.
      if (count_q == 2'd2) begin
        head_instr_d = tail_instr_q;
        head_pc_d    = tail_pc_q;
      end
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= 2'd0;
      head_instr_q <= INSTR_NOP;
      head_pc_q    <= '0;
      tail_instr_q <= INSTR_NOP;
      tail_pc_q    <= '0;
    end else begin
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

  assign count_o      = count_q;
  assign valid_o      = count_q != 2'd0;
  assign head_instr_o = head_instr_q;
  assign head_pc_o    = head_pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, redirect/squash, 2-entry buffer.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned redirects into a sticky fault state.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  import cpu_pkg::*;

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, redirect_target;
  logic [1:0]          buf_count;
  logic                req_valid, handshake, push, flush, redirect_en;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign redirect_target = bus.redirect_pc;
`else
  assign redirect_target = bus.redirect_pc & ~PC_WIDTH'(3);
`endif

  assign req_valid   = (state_q == REQ) && (buf_count != 2'd2);
  assign handshake   = req_valid && bus.imem_req_ready;
  assign redirect_en = bus.redirect_valid && (state_q != FAULT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    flush    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d  = fault_q;
`endif
    unique case (state_q)
      REQ: begin
        if (handshake) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_WIDTH'(4);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          push    = 1'b1;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (bus.imem_rsp_valid) state_d = REQ;
      end
      FAULT:   state_d = FAULT;
      default: state_d = REQ;
    endcase

    // A redirect squashes everything in flight; a request accepted this cycle is stale.
    if (redirect_en) begin
      flush = 1'b1;
      push  = 1'b0;
      pc_d  = redirect_target;
      if (state_q == REQ) state_d = handshake ? DRAIN : REQ;
      else                state_d = bus.imem_rsp_valid ? REQ : DRAIN;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        pc_d    = pc_q;
        state_d = FAULT;
        fault_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  fetch_buffer #(
    .PC_WIDTH(PC_WIDTH)
  ) u_buffer (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (bus.instr_ready),
    .flush_i     (flush),
    .instr_i     (bus.imem_rsp_data),
    .pc_i        (req_pc_q),
    .count_o     (buf_count),
    .valid_o     (bus.instr_valid),
    .head_instr_o(bus.instr),
    .head_pc_o   (bus.instr_pc)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: sequential-stream scoreboard, random-latency memory, directed scenarios.
module tb_fetch_unit;
  localparam int unsigned         PW     = 64;
  localparam logic [PW-1:0]       RST_PC = 64'h0;
  localparam logic [31:0]         NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if #(.PC_WIDTH(PW)) bus ();

  fetch_unit #(
    .PC_WIDTH(PW),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_consumed = 0;
  exp_t        exp_q[$];
  logic [63:0] exp_next_pc;
  bit          exp_halted = 1'b0;
  int          ready_pct = 100;
  int          k_min = 1;
  int          k_max = 1;
  int          ready_low = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    if (a == 64'h0) return 32'h0220_8463;
    if (a == 64'h4) return 32'h0281_3083;
    lo = a[31:0];
    return (lo * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The architectural stream is sequential words starting from the last reset/redirect target.
  task automatic top_up();
    while (!exp_halted && exp_q.size() < 8) begin
      exp_q.push_back('{pc: exp_next_pc, word: mem_word(exp_next_pc)});
      exp_next_pc = exp_next_pc + 64'd4;
    end
  endtask

  task automatic refill(input logic [63:0] pc);
    exp_q.delete();
    exp_halted  = 1'b0;
    exp_next_pc = pc;
    top_up();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    top_up();
  endtask

  task automatic do_reset(input logic rdy);
    #1;
    rst                = 1'b1;
    bus.instr_ready    = rdy;
    bus.redirect_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'(NOP));
    chk("rst_instr_pc", bus.instr_pc, 64'd0);
    chk("rst_fetch_fault", 64'(bus.fetch_fault), 64'd0);
    chk("rst_imem_addr", bus.imem_addr, RST_PC);
    step();
    step();
    #1;
    rst = 1'b0;
    refill(RST_PC);
    #1;
    chk("post_rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) begin
      exp_q.delete();
      exp_halted = 1'b1;
    end else begin
      refill(pc);
    end
`else
    refill({pc[63:2], 2'b00});
`endif
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input int max_cycles, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.imem_req_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no imem_req_valid, expected one within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic wait_instr(input int max_cycles, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.instr_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no instr_valid, expected one within %0d cycles", name, max_cycles);
    end
  endtask

  // Instruction memory: samples the handshake mid-cycle, answers k cycles later.
  initial begin : mem_model
    bit          hs;
    bit          pend;
    logic [63:0] a;
    logic [63:0] pa;
    int          cnt;
    pend = 1'b0;
    cnt  = 0;
    pa   = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b0;
    forever begin
      @(negedge clk);
      hs = !rst && bus.imem_req_valid && bus.imem_req_ready;
      a  = bus.imem_addr;
      if (hs) chk("single_outstanding", 64'(pend), 64'd0);
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (hs) begin
          pend = 1'b1;
          pa   = a;
          cnt  = $urandom_range(k_max, k_min);
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend               = 1'b0;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pa);
          end
        end
      end
      if (ready_low > 0) begin
        bus.imem_req_ready = 1'b0;
        ready_low--;
      end else begin
        bus.imem_req_ready = ($urandom_range(99, 0) < ready_pct);
      end
    end
  end

  // Scoreboard monitor: every consumed word must be the next expected one.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !bus.redirect_valid && bus.instr_valid && bus.instr_ready) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL consume_unexpected: got pc 0x%0h instr 0x%0h, expected no instruction",
                   bus.instr_pc, bus.instr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr_pc", bus.instr_pc, e.pc);
          chk("sb_instr", 64'(bus.instr), 64'(e.word));
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no end of test, expected finish before 600000");
    $fatal(1);
  end

  initial begin : stimulus
    logic [63:0] tgt;
    int          r;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    step();

    // Back-to-back fetch at k = 1, cycle-exact.
    k_min = 1; k_max = 1; ready_pct = 100;
    do_reset(1'b1);
    step();
    step();
    chk("t1_valid_c2", 64'(bus.instr_valid), 64'd1);
    chk("t1_instr_c2", 64'(bus.instr), 64'h0220_8463);
    chk("t1_pc_c2", bus.instr_pc, 64'h0);
    step();
    chk("t1_valid_c3", 64'(bus.instr_valid), 64'd0);
    step();
    chk("t1_valid_c4", 64'(bus.instr_valid), 64'd1);
    chk("t1_instr_c4", 64'(bus.instr), 64'h0281_3083);
    chk("t1_pc_c4", bus.instr_pc, 64'h4);

    // Backpressure fills the buffer, then drains in order.
    do_reset(1'b0);
    repeat (6) step();
    chk("t2_valid_full", 64'(bus.instr_valid), 64'd1);
    chk("t2_req_stalled", 64'(bus.imem_req_valid), 64'd0);
    chk("t2_addr_full", bus.imem_addr, 64'h8);
    bus.instr_ready = 1'b1;
    step();
    chk("t2_req_resume", 64'(bus.imem_req_valid), 64'd1);
    chk("t2_addr_resume", bus.imem_addr, 64'h8);
    chk("t2_head_pc", bus.instr_pc, 64'h4);
    repeat (6) step();

    // Redirect while waiting with one word buffered.
    k_min = 3; k_max = 3;
    do_reset(1'b0);
    repeat (5) step();
    chk("t3_pre_valid", 64'(bus.instr_valid), 64'd1);
    chk("t3_pre_wait", 64'(bus.imem_req_valid), 64'd0);
    do_redirect(64'h40);
    chk("t3_flushed", 64'(bus.instr_valid), 64'd0);
    chk("t3_draining", 64'(bus.imem_req_valid), 64'd0);
    wait_req(20, "t3_req_timeout");
    chk("t3_addr", bus.imem_addr, 64'h40);
    bus.instr_ready = 1'b1;
    wait_instr(20, "t3_instr_timeout");
    chk("t3_first_pc", bus.instr_pc, 64'h40);
    repeat (8) step();

    // Redirect on the handshake cycle, then memory stalls for 3 cycles.
    k_min = 1; k_max = 1;
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) break;
      step();
    end
    chk("t4_hs_found", 64'(bus.imem_req_valid && bus.imem_req_ready), 64'd1);
    ready_low = 3;
    do_redirect(64'h80);
    chk("t4_drain_no_req", 64'(bus.imem_req_valid), 64'd0);
    wait_req(10, "t4_req_timeout");
    chk("t4_addr", bus.imem_addr, 64'h80);
    repeat (12) step();

    // Reset while a k = 4 response is in flight.
    k_min = 4; k_max = 4;
    do_reset(1'b0);
    repeat (7) step();
    chk("t5_pre_valid", 64'(bus.instr_valid), 64'd1);
    chk("t5_pre_wait", 64'(bus.imem_req_valid), 64'd0);
    do_reset(1'b1);
    chk("t5_restart_addr", bus.imem_addr, RST_PC);
    repeat (20) step();

    // Misaligned redirect.
    k_min = 1; k_max = 1;
    do_reset(1'b1);
    repeat (4) step();
    do_redirect(64'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      chk("t6_fault", 64'(bus.fetch_fault), 64'd1);
      chk("t6_no_valid", 64'(bus.instr_valid), 64'd0);
      chk("t6_no_req", 64'(bus.imem_req_valid), 64'd0);
      step();
    end
`else
    wait_req(10, "t6_req_timeout");
    chk("t6_addr", bus.imem_addr, 64'h40);
    chk("t6_no_fault", 64'(bus.fetch_fault), 64'd0);
    repeat (10) step();
`endif

    // Random traffic against the sequential-stream model.
    do_reset(1'b1);
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        ready_pct = $urandom_range(100, 30);
        k_max     = $urandom_range(4, 1);
      end
      bus.instr_ready = ($urandom_range(9, 0) < 7);
      r = $urandom_range(999, 0);
      if (r < 3) begin
        do_reset(bus.instr_ready);
      end else if (r < 35) begin
        if (r < 8) tgt = 64'hFFFF_FFFF_FFFF_FFF0;
        else       tgt = 64'({$urandom_range(255, 0), 2'b00});
`ifndef FETCH_MISALIGN_CHECK_EN
        if (r % 3 == 0) tgt = tgt | 64'($urandom_range(3, 1));
`endif
        do_redirect(tgt);
      end else begin
        step();
      end
    end
    chk("progress", 64'(n_consumed > 200), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the mini CPU. Holds the PC, issues word requests to instruction memory over a valid/ready handshake, and buffers returned words in a 2-entry queue. It presents `{instr, instr_pc}` to the `control` decoder and the datapath. Branch and jump redirects from the execute stage reload the PC and squash any stale fetched words.

## Interface

Parameters:

- `PC_WIDTH`, 64: PC and address width.
- `RESET_PC`, 64'h0: PC value loaded on reset.

Ports:

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_addr`  out  PC_WIDTH: byte address of the requested word (always the PC register).
- `imem_rsp_valid`  in  1: response word valid.
- `imem_rsp_data`  in  32: instruction word.
- `redirect_valid`  in  1: taken branch or jump this cycle.
- `redirect_pc`  in  PC_WIDTH: target address.
- `instr_valid`  out  1: head of buffer valid.
- `instr`  out  32: instruction to `control`.
- `instr_pc`  out  PC_WIDTH: address of `instr`.
- `instr_ready`  in  1: decode consumes head.
- `fetch_fault`  out  1: sticky misaligned-redirect flag. Tied 0 unless `FETCH_MISALIGN_CHECK_EN`.

## Operation

- State machine: `REQ`, `WAIT`, `DRAIN`, plus `FAULT` when the macro is defined.
- `REQ`:
  - `imem_req_valid` = (`buf_count` < 2).
  - On `valid & ready`: latch `req_pc` <= `pc`, `pc` <= `pc + 4` (wraps modulo 2^PC_WIDTH), go to `WAIT`.
- `WAIT`:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: push `{imem_rsp_data, req_pc}`, go to `REQ`.
- `DRAIN`:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: discard the word, go to `REQ`.
- At most one outstanding request. A request issues only when the buffer has a free slot, so a response can never overflow the buffer.
- Buffer: 2-entry FIFO, head shown on `instr`/`instr_pc`. Pop on `instr_valid & instr_ready`. Push and pop in the same cycle is legal at any count.
- Redirect has priority over everything in its cycle:
  - `pc` <= `redirect_pc`, and the buffer is flushed. A same-cycle pop is ignored and a same-cycle push is dropped.
  - In `REQ` with a handshake the same cycle: the accepted request is stale, go to `DRAIN`.
  - In `REQ` without a handshake: stay in `REQ`.
  - In `WAIT`: if `imem_rsp_valid` the same cycle, drop it and go to `REQ`; otherwise go to `DRAIN`.
  - In `DRAIN`: stay in `DRAIN` until the response arrives.
- `imem_addr` may change while `imem_req_valid` is high without ready, but only on redirect. The instruction memory wrapper tolerates this.

## Timing

- Reset values:
  - State `REQ`, `pc` = `RESET_PC`, `buf_count` = 0.
  - `instr_valid` = 0, `instr` = 32'h0000_0013 (NOP), `instr_pc` = 0, `fetch_fault` = 0.
  - `imem_req_valid` = 1 from the first cycle after reset deasserts.
- Reset asserted mid-operation: all state returns to the reset values immediately. The next response from memory is ignored only if it arrives while `rst` is high. Memory is reset on the same `rst`.
- Latency:
  - Handshake in cycle N, response in cycle N+k (k ≥ 1).
  - `instr_valid` in cycle N+k+1, since buffer outputs are registered.
  - Next request in cycle N+k+1.
- Sustained throughput: one instruction per 2 cycles with k = 1.
- Redirect in cycle R: first request to `redirect_pc` in cycle R+1 at the earliest, or after the drain completes.

## Configuration

- `FETCH_MISALIGN_CHECK_EN` defined: a redirect with `redirect_pc[1:0] != 0` does the following:
  - sets `fetch_fault` (sticky until reset);
  - flushes the buffer;
  - enters `FAULT`, which holds `imem_req_valid` = 0 and ignores further redirects;
  - any in-flight response is discarded.
- Not defined: no check. `redirect_pc[1:0]` is ignored (forced to 00), and `fetch_fault` = 0.

## Structure

- Shared package `cpu_pkg`:
  - `PC_WIDTH` default;
  - `INSTR_NOP` = 32'h0000_0013;
  - `fetch_state_t` enum (`REQ`, `WAIT`, `DRAIN`, `FAULT`).
- Sub-module `fetch_buffer`: 2-entry FIFO with `push`, `pop`, `flush`, `count`, and a registered head. `fetch_unit` holds the FSM and PC logic.

## Test plan

- Reset, `RESET_PC` = 0, memory k = 1 with word 0x02208463 at 0 and 0x02813083 at 4, `instr_ready` = 1 → `instr` = 0x02208463 / `instr_pc` 0 in cycle 2, then 0x02813083 / `instr_pc` 4 in cycle 4.
- `instr_ready` = 0 → exactly two words buffered, `imem_req_valid` low with `pc` = 8. Raise ready → words drain in order, then a fetch to 8 issues.
- `redirect_valid`, `redirect_pc` = 0x40 while in `WAIT` with 1 word buffered → buffer empty, stale response discarded, next `imem_addr` = 0x40, first `instr_pc` = 0x40.
- Redirect in the same cycle as a request handshake, `imem_req_ready` low for 3 cycles afterward → `DRAIN` is observed and no stale word ever reaches `instr`.
- Response latency k = 4 with `rst` asserted at k = 2 → all outputs at reset values, fetch restarts at `RESET_PC`.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x42 → `fetch_fault` = 1, `instr_valid` = 0, no further requests. Without the macro, the same stimulus → fetch at 0x40.
